// File: rtl/mem_copy_engine_pkg.sv
// Shared types and defaults for the block-copy DMA helper.
// Holds the FSM state encoding and the overlap direction decision.
package mem_copy_pkg;

   localparam int DEF_DW    = 32;
   localparam int DEF_DEPTH = 64;
   localparam int DEF_AW    = 6;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_t;

   // Copy high-to-low when the destination starts inside the source span.
   function automatic logic is_desc(
      input int unsigned src,
      input int unsigned dst,
      input int unsigned len
   );
      return (dst > src) && (dst < src + len);
   endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Block-copy engine with memmove semantics on a single-port memory.
// One word every two cycles: a read cycle followed by a write cycle.
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW:0]   length,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          MemRead,
   output logic          MemWrite,
   output logic [31:0]   Address,
   output logic [DW-1:0] Write_data,
   input  logic [DW-1:0] Read_data
);

   localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

   state_t        state, state_nx;
   logic [AW-1:0] src_ptr, dst_ptr;
   logic [AW:0]   cnt;
   logic          desc, desc_nx, fits, go;

   assign fits = ({1'b0, src_addr} + length <= LIM)
              && ({1'b0, dst_addr} + length <= LIM);
   assign go   = (state == IDLE) && start;
   assign desc_nx = is_desc(32'(src_addr), 32'(dst_addr), 32'(length));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nx;
   end

   // Strobes decode from the state register only, never from start.
   always_comb begin
      state_nx   = state;
      busy       = 1'b1;
      done       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      Address    = '0;
      Write_data = '0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start && fits)
               state_nx = (length == '0) ? DONE : READ;
         end
         READ: begin
            MemRead  = 1'b1;
            Address  = 32'(src_ptr);
            state_nx = WRITE;
         end
         WRITE: begin
            MemWrite   = 1'b1;
            Address    = 32'(dst_ptr);
            Write_data = Read_data;
            state_nx   = (cnt == (AW+1)'(1)) ? DONE : READ;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         src_ptr <= '0;
         dst_ptr <= '0;
         cnt     <= '0;
         desc    <= 1'b0;
         err     <= 1'b0;
      end else begin
         err <= go && !fits;
         if (go && fits) begin
            desc <= desc_nx;
            cnt  <= length;
            if (desc_nx) begin
               src_ptr <= src_addr + AW'(length) - AW'(1);
               dst_ptr <= dst_addr + AW'(length) - AW'(1);
            end else begin
               src_ptr <= src_addr;
               dst_ptr <= dst_addr;
            end
         end else if (state == WRITE) begin
            cnt <= cnt - (AW+1)'(1);
            if (desc) begin
               src_ptr <= src_ptr - AW'(1);
               dst_ptr <= dst_ptr - AW'(1);
            end else begin
               src_ptr <= src_ptr + AW'(1);
               dst_ptr <= dst_ptr + AW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a synchronous-read memory model.
// Covers forward/overlap copies, boundary requests and mid-copy reset.
module tb_mem_copy_engine;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        start;
   logic [5:0]  src_addr, dst_addr;
   logic [6:0]  length;
   logic        busy, done, err, MemRead, MemWrite;
   logic [31:0] Address, Write_data, Read_data;

   logic [31:0] mem [64];
   logic        ld_we;
   logic [5:0]  ld_addr;
   logic [31:0] ld_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   int done_cyc, done_n, busy_n, err_n, rd_n, wr_n;
   int unsigned last_rd;
   int unsigned wq [$];

   mem_copy_engine dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Address    (Address),
      .Write_data (Write_data),
      .Read_data  (Read_data)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (ld_we)
         mem[ld_addr] <= ld_data;
      else if (MemWrite)
         mem[Address[5:0]] <= Write_data;
      if (MemRead && !MemWrite)
         Read_data <= mem[Address[5:0]];
   end

   always @(negedge CLK) begin
      if (RST_N) begin
         if (done) begin done_cyc = cyc; done_n++; end
         if (busy) busy_n++;
         if (err) err_n++;
         if (MemRead) begin rd_n++; last_rd = Address; end
         if (MemWrite) begin wr_n++; wq.push_back(Address); end
         total++;
         assert (!(MemRead && MemWrite) && !((MemRead || MemWrite) && !(busy && !done))
                 && Address[31:6] == 26'd0)
         else begin
            bad++;
            $error("FAIL proto: rd=%0b wr=%0b busy=%0b done=%0b addr=%0h required legal strobes",
                   MemRead, MemWrite, busy, done, Address);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic load(input int a, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = 6'(a); ld_data = d;
      @(negedge CLK);
      ld_we = 1'b0;
   endtask

   task automatic clr();
      wq.delete();
      done_cyc = 0; done_n = 0; busy_n = 0; err_n = 0; rd_n = 0; wr_n = 0;
      last_rd = 0;
   endtask

   task automatic do_start(input int s, input int d, input int l);
      start = 1'b1; src_addr = 6'(s); dst_addr = 6'(d); length = 7'(l);
      t0 = cyc;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && done_n == 0; i++) @(negedge CLK);
      tick(2);
   endtask

   initial begin
      RST_N = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
      ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      clr();
      tick(2);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_strobes", 32'({MemRead, MemWrite}), 0);
      chk("rst_addr", Address, 0);
      chk("rst_wdata", Write_data, 0);
      RST_N = 1'b1;
      tick(1);

      // forward copy with ignored starts while busy and in DONE
      load(0, 32'h11); load(1, 32'h22); load(2, 32'h33); load(3, 32'h44);
      for (int i = 8; i < 12; i++) load(i, 32'h0);
      load(20, 32'h5a5a);
      clr();
      do_start(0, 8, 4);
      start = 1'b1; src_addr = 6'd40; dst_addr = 6'd50; length = 7'd4;
      tick(1);
      start = 1'b0;
      tick(7);
      start = 1'b1; src_addr = 6'd0; dst_addr = 6'd20; length = 7'd1;
      tick(1);
      start = 1'b0;
      tick(4);
      chk("fwd_done_cycle", 32'(done_cyc - t0), 9);
      chk("fwd_done_count", 32'(done_n), 1);
      chk("fwd_busy_cycles", 32'(busy_n), 9);
      chk("fwd_writes", 32'(wr_n), 4);
      chk("fwd_mem8", mem[8], 32'h11);
      chk("fwd_mem9", mem[9], 32'h22);
      chk("fwd_mem10", mem[10], 32'h33);
      chk("fwd_mem11", mem[11], 32'h44);
      chk("fwd_src0", mem[0], 32'h11);
      chk("fwd_src3", mem[3], 32'h44);
      chk("ignored_start", mem[20], 32'h5a5a);

      // overlap, dst above src: must copy top-down
      load(2, 32'hA); load(3, 32'hB); load(4, 32'hC); load(5, 32'hD);
      load(6, 32'h0); load(7, 32'h0);
      clr();
      do_start(2, 4, 4);
      wait_done();
      chk("ovu_wr0", wq.size() > 0 ? wq[0] : 32'hffff, 7);
      chk("ovu_wr1", wq.size() > 1 ? wq[1] : 32'hffff, 6);
      chk("ovu_wr2", wq.size() > 2 ? wq[2] : 32'hffff, 5);
      chk("ovu_wr3", wq.size() > 3 ? wq[3] : 32'hffff, 4);
      chk("ovu_mem4", mem[4], 32'hA);
      chk("ovu_mem5", mem[5], 32'hB);
      chk("ovu_mem6", mem[6], 32'hC);
      chk("ovu_mem7", mem[7], 32'hD);

      // overlap, dst below src: bottom-up
      load(2, 32'h0); load(3, 32'h0);
      load(4, 32'hA); load(5, 32'hB); load(6, 32'hC); load(7, 32'hD);
      clr();
      do_start(4, 2, 4);
      wait_done();
      chk("ovd_wr0", wq.size() > 0 ? wq[0] : 32'hffff, 2);
      chk("ovd_wr1", wq.size() > 1 ? wq[1] : 32'hffff, 3);
      chk("ovd_wr2", wq.size() > 2 ? wq[2] : 32'hffff, 4);
      chk("ovd_wr3", wq.size() > 3 ? wq[3] : 32'hffff, 5);
      chk("ovd_mem2", mem[2], 32'hA);
      chk("ovd_mem3", mem[3], 32'hB);
      chk("ovd_mem4", mem[4], 32'hC);
      chk("ovd_mem5", mem[5], 32'hD);

      // zero length
      clr();
      do_start(5, 9, 0);
      wait_done();
      chk("len0_done_cycle", 32'(done_cyc - t0), 1);
      chk("len0_strobes", 32'(rd_n + wr_n), 0);
      chk("len0_busy", 32'(busy_n), 1);

      // out-of-range request
      clr();
      do_start(60, 0, 8);
      tick(3);
      chk("err_pulse", 32'(err_n), 1);
      chk("err_strobes", 32'(rd_n + wr_n), 0);
      chk("err_busy", 32'(busy_n), 0);
      chk("err_done", 32'(done_n), 0);

      // exactly reaching the top of memory
      load(63, 32'hC0FFEE);
      clr();
      do_start(56, 0, 8);
      wait_done();
      chk("top_done_cycle", 32'(done_cyc - t0), 17);
      chk("top_last_read", last_rd, 63);
      chk("top_mem7", mem[7], 32'hC0FFEE);

      // reset after the third write
      for (int i = 0; i < 8; i++) load(i, 32'h100 + 32'(i));
      for (int i = 16; i < 24; i++) load(i, 32'h0);
      clr();
      do_start(0, 16, 8);
      tick(6);
      RST_N = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_strobes", 32'({MemRead, MemWrite}), 0);
      chk("mid_rst_addr", Address, 0);
      tick(2);
      RST_N = 1'b1;
      tick(2);
      chk("mid_rst_mem16", mem[16], 32'h100);
      chk("mid_rst_mem18", mem[18], 32'h102);
      chk("mid_rst_mem19", mem[19], 32'h0);
      chk("mid_rst_mem23", mem[23], 32'h0);
      clr();
      do_start(0, 30, 2);
      wait_done();
      chk("post_rst_done_cycle", 32'(done_cyc - t0), 5);
      chk("post_rst_mem30", mem[30], 32'h100);
      chk("post_rst_mem31", mem[31], 32'h101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
